// File: rtl/mux_2x1_mfd_pkg.sv
// Shared constants and helpers for the hazard-free 2:1 multiplexer.
// MAX_WIDTH / MAX_STAGES bound the legal parameter ranges of mux_2x1_mfd.
// consensus_sop() gives the vector form of the per-bit SOP with consensus term.
package mux_2x1_mfd_pkg;

   localparam int unsigned MAX_WIDTH  = 64;
   localparam int unsigned MAX_STAGES = 4;

   // (~s & a) | (s & b) | (a & b): the a & b term holds the result when a == b
   function automatic logic [MAX_WIDTH-1:0] consensus_sop(
      input logic [MAX_WIDTH-1:0] a,
      input logic [MAX_WIDTH-1:0] b,
      input logic                 s
   );
      return ({MAX_WIDTH{~s}} & a) | ({MAX_WIDTH{s}} & b) | (a & b);
   endfunction

endpackage : mux_2x1_mfd_pkg

// File: rtl/mux_2x1_mfd_cell.sv
// Single-bit hazard-free 2:1 select in sum-of-products form.
// Ports:
//   i0_i : data bit chosen when s_i = 0
//   i1_i : data bit chosen when s_i = 1
//   s_i  : select
//   m_c  : combinational selected bit
module mux_2x1_mfd_cell (
   input  logic i0_i,
   input  logic i1_i,
   input  logic s_i,
   output logic m_c
);

   // Consensus term keeps m_c stable while s_i moves if both inputs agree
   assign m_c = (~s_i & i0_i) | (s_i & i1_i) | (i0_i & i1_i);

endmodule : mux_2x1_mfd_cell

// File: rtl/mux_2x1_mfd.sv
// Hazard-free 2:1 multiplexer with an optional registered output pipeline.
// Ports:
//   clk       : rising-edge clock (unused when STAGES = 0)
//   rst       : asynchronous active-high reset (unused when STAGES = 0)
//   i0, i1    : WIDTH-bit operands, i0 chosen when S = 0, i1 when S = 1
//   S         : select
//   in_valid  : qualifies i0/i1/S; travels alongside the data only
//   Y         : selected data, STAGES cycles after capture
//   out_valid : in_valid delayed by STAGES cycles
module mux_2x1_mfd
   import mux_2x1_mfd_pkg::*;
#(
   parameter int unsigned            WIDTH   = 1,
   parameter int unsigned            STAGES  = 1,
   parameter logic [WIDTH-1:0]       RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i0,
   input  logic [WIDTH-1:0] i1,
   input  logic             S,
   input  logic             in_valid,
   output logic [WIDTH-1:0] Y,
   output logic             out_valid
);

   // Elaboration-time parameter range checks
   if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("mux_2x1_mfd: WIDTH out of range 1..64");
   end
   if (STAGES > MAX_STAGES) begin : g_bad_stages
      $error("mux_2x1_mfd: STAGES out of range 0..4");
   end

   logic [WIDTH-1:0] m_c;

   // One SOP cell per bit
   for (genvar k = 0; k < WIDTH; k++) begin : g_bit
      mux_2x1_mfd_cell u_cell (
         .i0_i (i0[k]),
         .i1_i (i1[k]),
         .s_i  (S),
         .m_c  (m_c[k])
      );
   end

   if (STAGES == 0) begin : g_bypass
      // Purely combinational: clock and reset have no loads here
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;

      assign Y         = m_c;
      assign out_valid = in_valid;
   end else begin : g_pipe
      logic [WIDTH-1:0]  data_q [STAGES];
      logic [WIDTH-1:0]  data_d [STAGES];
      logic [STAGES-1:0] valid_q;
      logic [STAGES-1:0] valid_d;

      // Next-state: shift by one; data loads every cycle regardless of valid
      always_comb begin
         data_d[0]  = m_c;
         valid_d    = '0;
         valid_d[0] = in_valid;
         for (int unsigned i = 1; i < STAGES; i++) begin
            data_d[i]  = data_q[i-1];
            valid_d[i] = valid_q[i-1];
         end
      end

      // Async reset discards everything in flight
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
               data_q[i] <= RST_VAL;
            end
            valid_q <= '0;
         end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
         end
      end

      assign Y         = data_q[STAGES-1];
      assign out_valid = valid_q[STAGES-1];
   end

endmodule : mux_2x1_mfd

// File: tb/tb_mux_2x1_mfd.sv
// Self-checking bench for mux_2x1_mfd across four parameter sets:
//   u1  : WIDTH=1,  STAGES=1  (exhaustive table, consensus/hazard sequence)
//   u8  : WIDTH=8,  STAGES=3  (latency, async reset)
//   u16 : WIDTH=16, STAGES=2, RST_VAL=0xBEEF (random vs. reference model)
//   u0  : WIDTH=4,  STAGES=0  (combinational bypass)
module tb_mux_2x1_mfd;

   logic clk;
   logic rst;

   logic        s1, a1, b1, v1;
   logic        y1;
   logic        ov1;
   logic        s8, v8;
   logic [7:0]  a8, b8, y8;
   logic        ov8;
   logic        s16, v16;
   logic [15:0] a16, b16, y16;
   logic        ov16;
   logic        s0, v0;
   logic [3:0]  a0, b0, y0;
   logic        ov0;

   int checks;
   int failures;

   mux_2x1_mfd #(.WIDTH(1), .STAGES(1), .RST_VAL(1'b0)) u1 (
      .clk(clk), .rst(rst), .i0(a1), .i1(b1), .S(s1), .in_valid(v1),
      .Y(y1), .out_valid(ov1));

   mux_2x1_mfd #(.WIDTH(8), .STAGES(3), .RST_VAL(8'h00)) u8 (
      .clk(clk), .rst(rst), .i0(a8), .i1(b8), .S(s8), .in_valid(v8),
      .Y(y8), .out_valid(ov8));

   mux_2x1_mfd #(.WIDTH(16), .STAGES(2), .RST_VAL(16'hBEEF)) u16 (
      .clk(clk), .rst(rst), .i0(a16), .i1(b16), .S(s16), .in_valid(v16),
      .Y(y16), .out_valid(ov16));

   mux_2x1_mfd #(.WIDTH(4), .STAGES(0), .RST_VAL(4'h0)) u0 (
      .clk(clk), .rst(rst), .i0(a0), .i1(b0), .S(s0), .in_valid(v0),
      .Y(y0), .out_valid(ov0));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Advance to 1 ns after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic s;
      logic i0;
      logic i1;
      logic y;
   } vec_t;

   typedef struct {
      logic        v;
      logic [15:0] y;
   } exp16_t;

   vec_t   tbl[8];
   exp16_t q16[$];
   logic [7:0] exp_y8[5];
   logic       exp_ov8[5];

   initial begin
      #200000;
      $display("FAIL watchdog expired actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      checks   = 0;
      failures = 0;
      s1 = 0; a1 = 0; b1 = 0; v1 = 0;
      s8 = 0; a8 = 0; b8 = 0; v8 = 0;
      s16 = 0; a16 = 0; b16 = 0; v16 = 0;
      s0 = 0; a0 = 0; b0 = 0; v0 = 0;
      rst = 1'b1;

      // ---- Reset state ----
      #2;
      chk("rst_y1",    64'(y1),   64'h0);
      chk("rst_ov1",   64'(ov1),  64'h0);
      chk("rst_y8",    64'(y8),   64'h00);
      chk("rst_ov8",   64'(ov8),  64'h0);
      chk("rst_y16",   64'(y16),  64'hBEEF);
      chk("rst_ov16",  64'(ov16), 64'h0);
      @(negedge clk);
      rst = 1'b0;

      // ---- Exhaustive WIDTH=1 table ----
      tbl[0] = '{s:1'b0, i0:1'b0, i1:1'b0, y:1'b0};
      tbl[1] = '{s:1'b0, i0:1'b0, i1:1'b1, y:1'b0};
      tbl[2] = '{s:1'b0, i0:1'b1, i1:1'b0, y:1'b1};
      tbl[3] = '{s:1'b0, i0:1'b1, i1:1'b1, y:1'b1};
      tbl[4] = '{s:1'b1, i0:1'b0, i1:1'b0, y:1'b0};
      tbl[5] = '{s:1'b1, i0:1'b0, i1:1'b1, y:1'b1};
      tbl[6] = '{s:1'b1, i0:1'b1, i1:1'b0, y:1'b0};
      tbl[7] = '{s:1'b1, i0:1'b1, i1:1'b1, y:1'b1};
      for (int n = 0; n < 8; n++) begin
         step();
         s1 = tbl[n].s; a1 = tbl[n].i0; b1 = tbl[n].i1; v1 = 1'b1;
         repeat (10) @(posedge clk);
         #1;
         chk($sformatf("tbl_y[%0d]", n), 64'(y1), 64'(tbl[n].y));
         chk($sformatf("tbl_ov[%0d]", n), 64'(ov1), 64'h1);
      end

      // ---- Consensus: i0=i1=1, S toggles and goes X once ----
      a1 = 1'b1; b1 = 1'b1;
      step(); step();
      for (int n = 0; n < 10; n++) begin
         s1 = (n == 5) ? 1'bx : n[0];
         step();
         chk($sformatf("hazard_y[%0d]", n), 64'(y1), 64'h1);
      end

      // ---- Latency: one valid beat through 3 stages ----
      exp_y8[0] = 8'h00; exp_ov8[0] = 1'b0;
      exp_y8[1] = 8'h00; exp_ov8[1] = 1'b0;
      exp_y8[2] = 8'h3C; exp_ov8[2] = 1'b1;
      exp_y8[3] = 8'h00; exp_ov8[3] = 1'b0;
      exp_y8[4] = 8'h00; exp_ov8[4] = 1'b0;
      step();
      v8 = 1'b1; a8 = 8'hA5; b8 = 8'h3C; s8 = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         chk($sformatf("lat_ov[%0d]", c + 1), 64'(ov8), 64'(exp_ov8[c]));
         chk($sformatf("lat_y[%0d]", c + 1), 64'(y8), 64'(exp_y8[c]));
         v8 = 1'b0; a8 = 8'h00; b8 = 8'h00; s8 = 1'b0;
      end

      // ---- Async reset pulse between edges ----
      s8 = 1'b1; a8 = 8'h00; b8 = 8'hFF; v8 = 1'b1;
      s16 = 1'b1; a16 = 16'h0000; b16 = 16'hFFFF; v16 = 1'b1;
      repeat (4) step();
      chk("pre_rst_y8",  64'(y8),  64'hFF);
      chk("pre_rst_ov8", 64'(ov8), 64'h1);
      chk("pre_rst_y16", 64'(y16), 64'hFFFF);
      #2 rst = 1'b1;
      #1;
      chk("async_y8",   64'(y8),   64'h00);
      chk("async_ov8",  64'(ov8),  64'h0);
      chk("async_y16",  64'(y16),  64'hBEEF);
      chk("async_ov16", 64'(ov16), 64'h0);
      #1 rst = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         step();
         chk($sformatf("rel_y8[%0d]", c),  64'(y8),  (c >= 3) ? 64'hFF : 64'h00);
         chk($sformatf("rel_ov8[%0d]", c), 64'(ov8), (c >= 3) ? 64'h1  : 64'h0);
         if (c == 2) begin
            chk("rel_y16", 64'(y16), 64'hFFFF);
         end
      end

      // ---- Random against reference model, WIDTH=16 STAGES=2 ----
      for (int n = 0; n < 1000; n++) begin
         exp16_t e;
         if (q16.size() == 2) begin
            e = q16.pop_front();
            chk($sformatf("rnd_ov[%0d]", n), 64'(ov16), 64'(e.v));
            chk($sformatf("rnd_y[%0d]", n),  64'(y16),  64'(e.y));
         end
         s16 = 1'($urandom);
         a16 = 16'($urandom);
         b16 = 16'($urandom);
         v16 = 1'($urandom);
         e.v = v16;
         e.y = s16 ? b16 : a16;
         q16.push_back(e);
         step();
      end

      // ---- STAGES=0 combinational bypass ----
      step();
      a0 = 4'h1; b0 = 4'h2; s0 = 1'b0; v0 = 1'b0;
      #1;
      chk("byp_y_s0", 64'(y0),  64'h1);
      chk("byp_ov0",  64'(ov0), 64'h0);
      s0 = 1'b1; v0 = 1'b1;
      #1;
      chk("byp_y_s1", 64'(y0),  64'h2);
      chk("byp_ov1",  64'(ov0), 64'h1);
      a0 = 4'hA; b0 = 4'hA; s0 = 1'b0;
      #1;
      chk("byp_same", 64'(y0),  64'hA);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_mux_2x1_mfd
